robot_motor_sequencer: RTL and testbench
========================================

ROBOT_MOTOR_SEQUENCER -- requirements
Module: robot_motor_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent sensor/motor channels, legal range 1..16.
REQ-002 Parameter DEB_CYCLES, default 4: sensor debounce length in clocks, legal range 1..255.
REQ-003 Parameter DWELL_CYCLES, default 8: mandatory brake dwell on direction reversal, in clocks, legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global motion enable; 0 forces every channel's target to IDLE.
REQ-007 s1  input  NUM_CH  raw sensor 1, bit i = channel i.
REQ-008 s2  input  NUM_CH  raw sensor 2, bit i = channel i.
REQ-009 z1  output  NUM_CH  forward drive, bit i = channel i.
REQ-010 z2  output  NUM_CH  reverse drive, bit i = channel i.
REQ-011 dwell_o  output  NUM_CH  high while channel i is in DWELL.
REQ-012 state_o  output  2*NUM_CH  channel i state code at bits [2i+1:2i].

Function
REQ-013 Each channel SHALL debounce its raw pair {s1[i],s2[i]} with a candidate register cand, counter cnt and filtered register filt.
REQ-014 Per edge: raw != cand -> cand<=raw, cnt<=0; else if cnt == DEB_CYCLES-1 -> filt<=cand, cnt holds; else cnt<=cnt+1.
REQ-015 A raw value first sampled at edge 0 and held stable SHALL update filt at edge DEB_CYCLES; any intervening change restarts the count.
REQ-016 Target decode: enable=0 -> IDLE; filt 00 -> IDLE; 01 or 10 -> FWD; 11 -> REV.
REQ-017 Per-channel Moore FSM, states IDLE=2'b00, FWD=2'b01, REV=2'b10, DWELL=2'b11.
REQ-018 IDLE: target FWD -> FWD; target REV -> REV; else stay.
REQ-019 FWD: target IDLE -> IDLE; target REV -> DWELL; else stay. REV symmetric (target FWD -> DWELL).
REQ-020 Entry to DWELL SHALL load the dwell counter with DWELL_CYCLES-1; counter decrements each edge in DWELL, saturating at 0.
REQ-021 DWELL: target IDLE -> IDLE immediately (abort); else counter 0 -> current target (FWD or REV); else stay.
REQ-022 With stable target, DWELL SHALL last exactly DWELL_CYCLES clocks; a target flip between FWD and REV during DWELL does not reload the counter.
REQ-023 Outputs decode from state only: IDLE 00, FWD z1=1, REV z2=1, DWELL 00; dwell_o=1 only in DWELL.
REQ-024 z1[i] and z2[i] SHALL never be 1 in the same cycle, and FWD<->REV SHALL never occur without DWELL_CYCLES clocks of DWELL.
REQ-025 Latency from raw change sampled at edge 0 to state/outputs change SHALL be DEB_CYCLES+1 edges.
REQ-026 enable 0 stops motion at the next edge (FWD/REV -> IDLE, DWELL aborts); debounce keeps running.
REQ-027 Channels SHALL be fully independent; no shared counters.

Reset
REQ-028 reset=1 at an edge SHALL set cand=00, filt=00, cnt=0, dwell counter=0, state=IDLE for all channels, giving z1=z2=dwell_o=state_o=0.
REQ-029 reset SHALL override all inputs, including mid-debounce and mid-DWELL; after release, operation starts fresh with no remembered debounce progress.

Structure
REQ-030 Package robot_ctrl_pkg SHALL hold the state enum type and its 2-bit encodings.
REQ-031 Sub-module sensor_debounce (one 2-bit pair, parameter DEB_CYCLES) SHALL be instantiated per channel; the FSM and dwell counter live in the top under a generate loop.

Verification (NUM_CH=2, DEB_CYCLES=4, DWELL_CYCLES=8)
REQ-032 Reset held 2 clocks with s1=s2=11 -> all outputs 0; after release, with inputs held, channel 0 reaches REV (z2=1) at edge 5 after release.
REQ-033 ch0 raw 01 for 3 clocks then 00 -> z stays 00; raw 01 held -> z1=1 at edge 5.
REQ-034 ch0 in FWD, raw -> 11 -> DWELL at edge 5, z=00 and dwell_o=1 for 8 clocks, REV (z2=1) at edge 13; z1&z2 never both 1.
REQ-035 ch0 in DWELL, filt becomes 00 -> IDLE at next edge, REV never entered.
REQ-036 ch0 FWD, enable 0 -> z=00 next edge; enable 1 -> FWD next edge with no DWELL.
REQ-037 ch0 reversing while ch1 held FWD -> ch1 unaffected; reset asserted mid-DWELL -> both IDLE at that edge, dwell counter 0.

Source files
------------

// File: rtl/robot_ctrl_pkg.sv
// Shared types for the robot motor sequencer: channel state encoding and the
// sensor-pair to motion-target decode.
package robot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FWD   = 2'b01,
        ST_REV   = 2'b10,
        ST_DWELL = 2'b11
    } motor_state_e;

    // Wide enough for both the debounce length and the dwell length (1..255).
    localparam int CNT_W = 8;

    // Filtered pair 01 and 10 both mean forward; 11 means reverse.
    function automatic motor_state_e decode_target(input logic enable, input logic [1:0] filt);
        if (!enable) begin
            return ST_IDLE;
        end
        case (filt)
            2'b00:   return ST_IDLE;
            2'b11:   return ST_REV;
            default: return ST_FWD;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounces one raw sensor pair: a value must be sampled unchanged on
// DEB_CYCLES+1 consecutive edges before it reaches filt.
module sensor_debounce
    import robot_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] raw,
    output logic [1:0] filt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       cand;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= 2'b00;
            cnt  <= '0;
            filt <= 2'b00;
        end else if (raw != cand) begin
            cand <= raw;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/robot_motor_sequencer.sv
// Multi-channel motor sequencer: debounced sensor pairs select forward/reverse
// drive, with a mandatory brake dwell on every direction reversal.
module robot_motor_sequencer
    import robot_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     s1,
    input  logic [NUM_CH-1:0]     s2,
    output logic [NUM_CH-1:0]     z1,
    output logic [NUM_CH-1:0]     z2,
    output logic [NUM_CH-1:0]     dwell_o,
    output logic [2*NUM_CH-1:0]   state_o
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       filt;
        motor_state_e     target;
        motor_state_e     state;
        motor_state_e     state_nxt;
        logic [CNT_W-1:0] dwell_cnt;
        logic [CNT_W-1:0] dwell_cnt_nxt;
        logic             z1_q;
        logic             z2_q;
        logic             dwell_q;

        sensor_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  ({s1[i], s2[i]}),
            .filt (filt)
        );

        assign target = decode_target(enable, filt);

        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            state_nxt     = state;
            dwell_cnt_nxt = dwell_cnt;
            if (state == ST_DWELL && dwell_cnt != '0) begin
                dwell_cnt_nxt = dwell_cnt - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (target != ST_IDLE) begin
                        state_nxt = target;
                    end
                end
                ST_FWD: begin
                    if (target == ST_IDLE) begin
                        state_nxt = ST_IDLE;
                    end else if (target == ST_REV) begin
                        state_nxt     = ST_DWELL;
                        dwell_cnt_nxt = DWELL_LOAD;
                    end
                end
                ST_REV: begin
                    if (target == ST_IDLE) begin
                        state_nxt = ST_IDLE;
                    end else if (target == ST_FWD) begin
                        state_nxt     = ST_DWELL;
                        dwell_cnt_nxt = DWELL_LOAD;
                    end
                end
                ST_DWELL: begin
                    // Losing the target aborts the brake; otherwise exit only once
                    // the count has run out, towards whatever the target is now.
                    if (target == ST_IDLE) begin
                        state_nxt = ST_IDLE;
                    end else if (dwell_cnt == '0) begin
                        state_nxt = target;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with state.
        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= ST_IDLE;
                dwell_cnt <= '0;
                z1_q      <= 1'b0;
                z2_q      <= 1'b0;
                dwell_q   <= 1'b0;
            end else begin
                state     <= state_nxt;
                dwell_cnt <= dwell_cnt_nxt;
                z1_q      <= (state_nxt == ST_FWD);
                z2_q      <= (state_nxt == ST_REV);
                dwell_q   <= (state_nxt == ST_DWELL);
            end
        end

        assign z1[i]             = z1_q;
        assign z2[i]             = z2_q;
        assign dwell_o[i]        = dwell_q;
        assign state_o[2*i +: 2] = state;
    end

endmodule

// File: tb/tb_robot_motor_sequencer.sv
// Self-checking bench for robot_motor_sequencer: directed scenarios plus a
// randomized run against a run-length / dwell-age reference model.
module tb_robot_motor_sequencer;

    localparam int NUM_CH = 2;
    localparam int DEB    = 4;
    localparam int DWELL  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_FWD   = 1;
    localparam int M_REV   = 2;
    localparam int M_DWELL = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b1;
    logic [NUM_CH-1:0]   s1 = '0;
    logic [NUM_CH-1:0]   s2 = '0;
    logic [NUM_CH-1:0]   z1;
    logic [NUM_CH-1:0]   z2;
    logic [NUM_CH-1:0]   dwell_o;
    logic [2*NUM_CH-1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    robot_motor_sequencer #(
        .NUM_CH      (NUM_CH),
        .DEB_CYCLES  (DEB),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .s1     (s1),
        .s2     (s2),
        .z1     (z1),
        .z2     (z2),
        .dwell_o(dwell_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: a raw value reaches filt once it has been seen on DEB+1
    // consecutive edges (the reset edge counts as a sample of 00); dwell is
    // tracked as the number of clocks already spent braking.
    int         m_run   [NUM_CH];
    logic [1:0] m_last  [NUM_CH];
    logic [1:0] m_filt  [NUM_CH];
    int         m_state [NUM_CH];
    int         m_age   [NUM_CH];

    function automatic int want(input logic en, input logic [1:0] f);
        if (!en || f == 2'b00) return M_IDLE;
        return (f == 2'b11) ? M_REV : M_FWD;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_run[c]   <= 1;
                m_last[c]  <= 2'b00;
                m_filt[c]  <= 2'b00;
                m_state[c] <= M_IDLE;
                m_age[c]   <= 0;
            end else begin
                if ({s1[c], s2[c]} == m_last[c]) begin
                    if (m_run[c] < 1000) m_run[c] <= m_run[c] + 1;
                    if (m_run[c] + 1 >= DEB + 1) m_filt[c] <= {s1[c], s2[c]};
                end else begin
                    m_run[c]  <= 1;
                    m_last[c] <= {s1[c], s2[c]};
                end
                case (m_state[c])
                    M_IDLE: m_state[c] <= want(enable, m_filt[c]);
                    M_FWD, M_REV: begin
                        if (want(enable, m_filt[c]) == M_IDLE) begin
                            m_state[c] <= M_IDLE;
                        end else if (want(enable, m_filt[c]) != m_state[c]) begin
                            m_state[c] <= M_DWELL;
                            m_age[c]   <= 1;
                        end
                    end
                    default: begin
                        if (want(enable, m_filt[c]) == M_IDLE) begin
                            m_state[c] <= M_IDLE;
                        end else if (m_age[c] >= DWELL) begin
                            m_state[c] <= want(enable, m_filt[c]);
                        end else begin
                            m_age[c] <= m_age[c] + 1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_raw(input int ch, input logic [1:0] v);
        s1[ch] = v[1];
        s2[ch] = v[0];
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] exp_z2;
        reset  = 1'b1;
        enable = 1'b1;
        s1     = '1;
        s2     = '1;
        step();
        step();
        n_checks++;
        if ({z1, z2, dwell_o, state_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs z1=%b z2=%b dwell=%b state=%b expected all zero",
                     z1, z2, dwell_o, state_o);
        end
        reset = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            step();
            exp_z2 = (k == 5) ? '1 : '0;
            n_checks++;
            if (z2 !== exp_z2 || z1 !== '0) begin
                n_errors++;
                $display("FAIL reset_release edge %0d z1=%b z2=%b expected z1=00 z2=%b",
                         k, z1, z2, exp_z2);
            end
        end
        n_checks++;
        if (state_o !== 4'b1010) begin
            n_errors++;
            $display("FAIL reset_release_state state=%b expected 1010", state_o);
        end
    endtask

    task automatic test_glitch();
        s1 = '0;
        s2 = '0;
        do_reset(2);
        for (int k = 0; k < 6; k++) step();
        set_raw(0, 2'b01);
        for (int k = 0; k < 3; k++) step();
        set_raw(0, 2'b00);
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (z1[0] !== 1'b0 || z2[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL glitch_filtered cycle %0d z1=%b z2=%b expected 0 0", k, z1[0], z2[0]);
            end
        end
        set_raw(0, 2'b01);
        for (int k = 0; k <= 5; k++) begin
            step();
            n_checks++;
            if (z1[0] !== (k == 5)) begin
                n_errors++;
                $display("FAIL debounce_latency edge %0d z1=%b expected %b", k, z1[0], (k == 5));
            end
        end
    endtask

    task automatic test_reverse();
        int exp_st;
        set_raw(0, 2'b11);
        for (int k = 0; k <= 13; k++) begin
            step();
            exp_st = (k < 5) ? M_FWD : (k < 13) ? M_DWELL : M_REV;
            n_checks++;
            if (state_o[1:0] !== 2'(exp_st) || z1[0] !== (exp_st == M_FWD) ||
                z2[0] !== (exp_st == M_REV) || dwell_o[0] !== (exp_st == M_DWELL) ||
                (z1 & z2) !== '0) begin
                n_errors++;
                $display("FAIL reverse_dwell edge %0d state=%b z1=%b z2=%b dwell=%b expected state=%0d",
                         k, state_o[1:0], z1[0], z2[0], dwell_o[0], exp_st);
            end
        end
    endtask

    task automatic test_abort();
        int exp_st;
        set_raw(0, 2'b01);
        for (int k = 0; k <= 16; k++) begin
            if (k == 5) set_raw(0, 2'b00);
            step();
            exp_st = (k < 5) ? M_REV : (k < 10) ? M_DWELL : M_IDLE;
            n_checks++;
            if (state_o[1:0] !== 2'(exp_st) || (k >= 5 && z1[0] !== 1'b0)) begin
                n_errors++;
                $display("FAIL dwell_abort edge %0d state=%b z1=%b expected state=%0d z1=0",
                         k, state_o[1:0], z1[0], exp_st);
            end
        end
    endtask

    task automatic test_enable();
        set_raw(0, 2'b01);
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (z1[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL enable_setup z1=%b expected 1", z1[0]);
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (state_o[1:0] !== 2'b00 || z1[0] !== 1'b0 || dwell_o[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL enable_off cycle %0d state=%b z1=%b dwell=%b expected 00 0 0",
                         k, state_o[1:0], z1[0], dwell_o[0]);
            end
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (state_o[1:0] !== 2'b01 || z1[0] !== 1'b1 || dwell_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_on state=%b z1=%b dwell=%b expected 01 1 0",
                     state_o[1:0], z1[0], dwell_o[0]);
        end
    endtask

    task automatic test_independent();
        set_raw(1, 2'b10);
        for (int k = 0; k < 6; k++) step();
        set_raw(0, 2'b11);
        for (int k = 0; k <= 13; k++) begin
            step();
            n_checks++;
            if (state_o[3:2] !== 2'b01 || z1[1] !== 1'b1 || dwell_o[1] !== 1'b0) begin
                n_errors++;
                $display("FAIL ch1_independent edge %0d state=%b z1=%b dwell=%b expected 01 1 0",
                         k, state_o[3:2], z1[1], dwell_o[1]);
            end
        end
        n_checks++;
        if (state_o[1:0] !== 2'b10) begin
            n_errors++;
            $display("FAIL ch0_reversed state=%b expected 10", state_o[1:0]);
        end
        set_raw(0, 2'b01);
        for (int k = 0; k < 7; k++) step();
        n_checks++;
        if (dwell_o[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_dwell_setup dwell=%b expected 1", dwell_o[0]);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({z1, z2, dwell_o, state_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_dwell z1=%b z2=%b dwell=%b state=%b expected all zero",
                     z1, z2, dwell_o, state_o);
        end
        reset = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            step();
            n_checks++;
            if (state_o !== ((k == 5) ? 4'b0101 : 4'b0000)) begin
                n_errors++;
                $display("FAIL fresh_after_reset edge %0d state=%b expected %b",
                         k, state_o, (k == 5) ? 4'b0101 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        int                  hold [NUM_CH];
        int                  en_hold;
        logic [2*NUM_CH-1:0] exp_state;
        logic [NUM_CH-1:0]   exp_z1;
        logic [NUM_CH-1:0]   exp_z2;
        logic [NUM_CH-1:0]   exp_dw;
        for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
        en_hold = 0;
        enable  = 1'b1;
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold[c] == 0) begin
                    set_raw(c, 2'($urandom_range(0, 3)));
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 25);
                end else begin
                    hold[c]--;
                end
            end
            if (en_hold > 0) begin
                en_hold--;
            end else begin
                enable = ($urandom_range(0, 19) != 0);
                en_hold = $urandom_range(0, 6);
            end
            reset = ($urandom_range(0, 399) == 0);
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                exp_state[2*c +: 2] = 2'(m_state[c]);
                exp_z1[c]           = (m_state[c] == M_FWD);
                exp_z2[c]           = (m_state[c] == M_REV);
                exp_dw[c]           = (m_state[c] == M_DWELL);
            end
            n_checks++;
            if (state_o !== exp_state || z1 !== exp_z1 || z2 !== exp_z2 ||
                dwell_o !== exp_dw || (z1 & z2) !== '0) begin
                n_errors++;
                $display("FAIL random cycle %0d state=%b z1=%b z2=%b dwell=%b expected state=%b z1=%b z2=%b dwell=%b",
                         n, state_o, z1, z2, dwell_o, exp_state, exp_z1, exp_z2, exp_dw);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_reverse();
        test_abort();
        test_enable();
        test_independent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
